// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked LEGv8 ALU control with multi-cycle MUL/UDIV
// Ports:
//   clk, rst_n (async active-low), flush (sync discard)
//   in_valid/in_ready  : upstream decode request handshake
//   alu_op, instruction: ALUOp and instruction word (only [31:21] decoded)
//   out_valid/out_ready: downstream result handshake
//   operation_code, illegal: registered decode result
//   mc_busy            : a MUL/UDIV latency countdown is in progress
module alu_ctrl_seq #(
  parameter int OPC_W   = 11,
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation_code,
  output logic            illegal,
  output logic            mc_busy
);
  typedef enum logic [1:0] {IDLE, BUSY, VALID} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d, dec_op;
  logic              ill_q, ill_d, dec_ill, dec_mc, accept;
  logic [3:0]        dec_lat;
  logic [OPC_W-1:0]  opc;
  logic              unused_instr;
  assign opc          = instruction[31:21];
  assign unused_instr = ^instruction[20:0];
  // Case compare sends X/Z on alu_op to the illegal default instead of a valid code.
  always_comb begin
    dec_op  = '1;
    dec_ill = 1'b1;
    dec_mc  = 1'b0;
    dec_lat = '0;
    case (alu_op)
      2'b00: begin dec_op = OP_W'(4'b0010); dec_ill = 1'b0; end
      2'b01: begin dec_op = OP_W'(4'b0111); dec_ill = 1'b0; end
      2'b10, 2'b11: begin
        dec_ill = 1'b0;
        case (opc)
          11'b10001011000: dec_op = OP_W'(4'b0010);
          11'b11001011000: dec_op = OP_W'(4'b0110);
          11'b10001010000: dec_op = OP_W'(4'b0000);
          11'b10101010000: dec_op = OP_W'(4'b0001);
          11'b11001010000: dec_op = OP_W'(4'b0011);
          11'b11010011011: dec_op = OP_W'(4'b1000);
          11'b11010011010: dec_op = OP_W'(4'b1001);
          11'b10011011000: begin dec_op = OP_W'(4'b1010); dec_mc = 1'b1; dec_lat = 4'(MUL_LAT); end
          11'b10011010110: begin dec_op = OP_W'(4'b1011); dec_mc = 1'b1; dec_lat = 4'(DIV_LAT); end
          default:         begin dec_op = '1; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_op = '1; dec_ill = 1'b1; end
    endcase
  end
  // Accepting in VALID requires out_ready, so a held result is never overwritten.
  assign in_ready = !flush && (state_q == IDLE || (state_q == VALID && out_ready));
  assign accept   = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_d    = '0;
      ill_d   = 1'b0;
    end else if (accept) begin
      state_d = dec_mc ? BUSY : VALID;
      cnt_d   = dec_mc ? dec_lat - 4'd1 : '0;
      op_d    = dec_op;
      ill_d   = dec_ill;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q <= 4'd1) ? VALID : BUSY;
    end else if (state_q == VALID && out_ready) begin
      state_d = IDLE;
    end else if (state_q != IDLE && state_q != VALID) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end
  assign out_valid      = state_q == VALID;
  assign mc_busy        = state_q == BUSY;
  assign operation_code = op_q;
  assign illegal        = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000,
    AND_ = 11'b10001010000, ORR = 11'b10101010000, EOR = 11'b11001010000,
    LSL = 11'b11010011011, LSR = 11'b11010011010, MUL = 11'b10011011000,
    UDIV = 11'b10011010110;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] alu_op = 2'b00;
  logic [31:0] instruction = '0;
  logic in_ready, out_valid, illegal, mc_busy;
  logic [3:0] operation_code;
  int n_cmp = 0, n_err = 0;
  alu_ctrl_seq #(.OPC_W(11), .OP_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .instruction(instruction), .out_valid(out_valid),
    .out_ready(out_ready), .operation_code(operation_code), .illegal(illegal),
    .mc_busy(mc_busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] a, input logic [10:0] o, input logic r);
    in_valid    = v;
    alu_op      = a;
    instruction = {o, 21'h0A5A5};
    out_ready   = r;
    #1;
  endtask
  task automatic test_reset;
    #1;
    n_cmp++;
    if ({out_valid, mc_busy, operation_code, illegal} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b busy=%b op=%b ill=%b, want all 0", out_valid, mc_busy, operation_code, illegal);
    end
    tick;
    rst_n = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_single;
    drive(1, 2'b10, ADD, 1);
    tick;
    n_cmp++;
    if ({out_valid, operation_code, illegal} !== 6'b1_0010_0) begin
      n_err++;
      $display("FAIL single_add: got ov=%b op=%b ill=%b want 1/0010/0", out_valid, operation_code, illegal);
    end
    drive(0, 2'b10, ADD, 1);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: ov=%b want 0", out_valid); end
  endtask
  task automatic test_stream;
    logic [10:0] opcs [7] = '{ADD, SUB, AND_, ORR, EOR, LSL, LSR};
    logic [3:0]  exps [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1001};
    for (int i = 0; i < 7; i++) begin
      drive(1, 2'b10, opcs[i], 1);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      tick;
      n_cmp++;
      if ({out_valid, operation_code, illegal} !== {1'b1, exps[i], 1'b0}) begin
        n_err++;
        $display("FAIL stream[%0d]: got ov=%b op=%b ill=%b want 1/%b/0", i, out_valid, operation_code, illegal, exps[i]);
      end
    end
    drive(0, 2'b10, ADD, 1);
    tick;
  endtask
  task automatic test_aluop;
    logic [1:0] aops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [10:0] opcs [4] = '{11'b11111111111, 11'b01010101010, 11'b11111111111, SUB};
    logic [4:0] exps [4] = '{5'b0010_0, 5'b0111_0, 5'b1111_1, 5'b0110_0};
    for (int i = 0; i < 4; i++) begin
      drive(1, aops[i], opcs[i], 1);
      tick;
      n_cmp++;
      if ({out_valid, operation_code, illegal} !== {1'b1, exps[i]}) begin
        n_err++;
        $display("FAIL aluop[%0d]: got ov=%b op=%b ill=%b want 1/%b/%b", i, out_valid, operation_code, illegal, exps[i][4:1], exps[i][0]);
      end
    end
    drive(0, 2'b10, ADD, 1);
    tick;
  endtask
  task automatic test_multicycle(input logic [10:0] opc, input int lat, input logic [3:0] exp);
    drive(1, 2'b10, opc, 1);
    tick;
    drive(1, 2'b10, ADD, 1);
    for (int k = 1; k < lat; k++) begin
      n_cmp++;
      if ({mc_busy, in_ready, out_valid} !== 3'b100) begin
        n_err++;
        $display("FAIL mc_busy[%b,T+%0d]: got busy=%b rdy=%b ov=%b want 1/0/0", exp, k, mc_busy, in_ready, out_valid);
      end
      tick;
    end
    n_cmp++;
    if ({out_valid, mc_busy, operation_code, illegal} !== {2'b10, exp, 1'b0}) begin
      n_err++;
      $display("FAIL mc_result[%b]: got ov=%b busy=%b op=%b ill=%b want 1/0/%b/0", exp, out_valid, mc_busy, operation_code, illegal, exp);
    end
    drive(0, 2'b10, ADD, 1);
    tick;
  endtask
  task automatic test_stall;
    drive(1, 2'b10, SUB, 0);
    tick;
    drive(1, 2'b10, ADD, 0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid, operation_code, in_ready} !== {1'b1, 4'b0110, 1'b0}) begin
        n_err++;
        $display("FAIL stall[%0d]: got ov=%b op=%b rdy=%b want 1/0110/0", k, out_valid, operation_code, in_ready);
      end
      tick;
    end
    drive(1, 2'b10, ADD, 1);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick;
    n_cmp++;
    if ({out_valid, operation_code} !== 5'b1_0010) begin
      n_err++;
      $display("FAIL stall_next: got ov=%b op=%b want 1/0010", out_valid, operation_code);
    end
    drive(0, 2'b10, ADD, 1);
    tick;
  endtask
  task automatic test_back_to_back;
    drive(1, 2'b10, ADD, 1);
    tick;
    drive(1, 2'b10, MUL, 1);
    tick;
    drive(0, 2'b10, ADD, 1);
    n_cmp++;
    if ({out_valid, mc_busy} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_busy: got ov=%b busy=%b want 0/1", out_valid, mc_busy);
    end
    for (int k = 1; k < MUL_LAT; k++) tick;
    n_cmp++;
    if ({out_valid, operation_code} !== 5'b1_1010) begin
      n_err++;
      $display("FAIL b2b_mul: got ov=%b op=%b want 1/1010", out_valid, operation_code);
    end
    tick;
  endtask
  task automatic test_flush;
    drive(1, 2'b10, UDIV, 1);
    tick;
    drive(0, 2'b10, ADD, 1);
    tick;
    n_cmp++;
    if (mc_busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", mc_busy); end
    flush = 1;
    drive(1, 2'b10, ADD, 1);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick;
    flush = 0;
    drive(0, 2'b10, ADD, 1);
    n_cmp++;
    if ({out_valid, mc_busy, operation_code, illegal, in_ready} !== 8'b00_0000_0_1) begin
      n_err++;
      $display("FAIL flush_cleared: got ov=%b busy=%b op=%b ill=%b rdy=%b want 0/0/0000/0/1", out_valid, mc_busy, operation_code, illegal, in_ready);
    end
    for (int k = 0; k < DIV_LAT; k++) tick;
    n_cmp++;
    if ({out_valid, mc_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_no_stale: got ov=%b busy=%b want 0/0", out_valid, mc_busy);
    end
  endtask
  task automatic test_reset_mid;
    drive(1, 2'b10, UDIV, 1);
    tick;
    drive(0, 2'b10, ADD, 1);
    tick;
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({out_valid, mc_busy, operation_code, illegal} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid: got ov=%b busy=%b op=%b ill=%b want all 0", out_valid, mc_busy, operation_code, illegal);
    end
    tick;
    rst_n = 1;
    drive(1, 2'b10, ORR, 1);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready: got %b want 1", in_ready); end
    tick;
    n_cmp++;
    if ({out_valid, operation_code, illegal} !== 6'b1_0001_0) begin
      n_err++;
      $display("FAIL reset_mid_orr: got ov=%b op=%b ill=%b want 1/0001/0", out_valid, operation_code, illegal);
    end
    drive(0, 2'b10, ADD, 1);
    tick;
  endtask
  initial begin
    test_reset;
    test_single;
    test_stream;
    test_aluop;
    test_multicycle(MUL, MUL_LAT, 4'b1010);
    test_multicycle(UDIV, DIV_LAT, 4'b1011);
    test_stall;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, handshaked ALU control unit for the multi-cycle/pipelined LEGv8 datapath. It decodes the ALUOp field and the R-format opcode (instruction[31:21]) into a 4-bit ALU operation code. It extends the base set (ADD/SUB/AND/ORR) with EOR, LSL, LSR, MUL and UDIV, and flags illegal opcodes. MUL and UDIV are multi-cycle operations: the block holds them for a parametrised latency and stalls upstream via valid/ready.

Parameters:
OPC_W, 11, opcode field width (instruction[31:21]).
OP_W, 4, operation code width.
MUL_LAT, 3, cycles from accept to out_valid for MUL (legal range 2..15).
DIV_LAT, 8, cycles from accept to out_valid for UDIV (legal range 2..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush; discards any in-flight op.
in_valid  in  1  upstream has a decode request.
in_ready  out  1  block can accept a request this cycle.
alu_op  in  2  ALUOp {ALUOp1, ALUOp0} from main control.
instruction  in  32  full instruction word; only [31:21] decoded.
out_valid  out  1  operation_code/illegal are valid.
out_ready  in  1  ALU consumes the result.
operation_code  out  OP_W  ALU operation select.
illegal  out  1  opcode not in table (with alu_op=1x).
mc_busy  out  1  a multi-cycle op is counting down.

Behaviour:
- Decode, with priority top to bottom:
  - alu_op=00 -> 0010 (address add).
  - alu_op=01 -> 0111 (pass B, CBZ).
  - alu_op=1x, by opcode:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - 11001010000 EOR -> 0011
    - 11010011011 LSL -> 1000
    - 11010011010 LSR -> 1001
    - 10011011000 MUL -> 1010, multi-cycle, MUL_LAT
    - 10011010110 UDIV -> 1011, multi-cycle, DIV_LAT
    - any other opcode -> 1111 with illegal=1, single-cycle.
- Decode is fully specified; X on alu_op is never decoded as a valid code.
- State machine IDLE / BUSY / VALID:
  - IDLE: in_ready=1. On accept (in_valid & in_ready):
    - single-cycle op -> VALID next cycle;
    - multi-cycle op -> BUSY, counter loaded with LAT-1.
  - BUSY: in_ready=0, mc_busy=1, counter decrements each cycle. When the counter reaches 1 -> VALID next cycle. Result therefore appears exactly LAT cycles after accept.
  - VALID: out_valid=1. Outputs are held stable until out_ready.
    - in_ready = out_ready, giving back-to-back throughput of one op per cycle for single-cycle ops.
    - On out_ready with no accept -> IDLE.
    - On out_ready with an accept -> next op's state as from IDLE.
- Decoded code and illegal are captured at accept and held unchanged through BUSY/VALID.
- flush=1 (synchronous, overrides everything except reset):
  - in_ready forced 0 that cycle;
  - next state IDLE; out_valid and mc_busy cleared next cycle;
  - operation_code and illegal reset to 0;
  - any in-flight or presented op is dropped.
- Reset (rst_n=0, any time including mid-BUSY):
  - immediately: state IDLE, out_valid=0, mc_busy=0, operation_code=0000, illegal=0, counter=0;
  - in_ready=1 after release.
- out_valid never drops without out_ready, except on flush or reset.

Test Plan:
- Reset then in_valid with alu_op=10, opcode 10001011000 at cycle T -> out_valid at T+1, operation_code=0010, illegal=0; with out_ready=1, in_ready stays 1.
- Stream ADD, SUB, AND, ORR, EOR, LSL, LSR with out_ready=1 on consecutive cycles -> 7 consecutive results 0010, 0110, 0000, 0001, 0011, 1000, 1001; no bubbles.
- alu_op=00 and alu_op=01 with an arbitrary instruction -> 0010 and 0111; opcode 11111111111 with alu_op=10 -> 1111, illegal=1.
- MUL accepted at T (MUL_LAT=3) -> mc_busy high T+1..T+2, in_ready low, out_valid at T+3 with 1010. Repeat with UDIV and DIV_LAT=8 -> out_valid at T+8 with 1011.
- out_valid with out_ready=0 for 4 cycles -> operation_code stable, in_ready=0; new in_valid is not accepted until out_ready rises.
- flush asserted mid-BUSY -> IDLE next cycle with out_valid=0, mc_busy=0. Separately, rst_n pulsed low mid-BUSY -> outputs cleared asynchronously; after release an ORR decodes to 0001 normally.
